// File: rtl/crvga_kb_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | crvga_kb_pkg : VGA 640x480 timing and PS/2 frame constants          |
// | Rev 1.0                                                             |
// +---------------------------------------------------------------------+
package crvga_kb_pkg;

   localparam int H_VIS   = 640;
   localparam int H_FP    = 16;
   localparam int H_SYNC  = 96;
   localparam int H_BP    = 48;
   localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

   localparam int V_VIS   = 480;
   localparam int V_FP    = 10;
   localparam int V_SYNC  = 2;
   localparam int V_BP    = 29;
   localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

   localparam int KB_TIMEOUT = 65536;

   localparam int PS2_FRAME_BITS = 11;
   localparam int PS2_START_IDX  = 0;
   localparam int PS2_PARITY_IDX = 9;
   localparam int PS2_STOP_IDX   = 10;

   typedef logic [PS2_FRAME_BITS-1:0] ps2_frame_t;

   typedef struct packed {
      logic r;
      logic g;
      logic b;
   } rgb_t;

   // Bit 0 is the start bit (first on the wire); data plus parity must hold an odd count of ones.
   function automatic logic ps2_frame_ok(input ps2_frame_t f);
      return (f[PS2_START_IDX] == 1'b0) && (f[PS2_STOP_IDX] == 1'b1) &&
             (^f[PS2_PARITY_IDX:1]);
   endfunction

endpackage
`default_nettype wire

// File: rtl/crvga_kb_if.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | crvga_kb_if : VGA pixel/sync bus and PS/2 pins of crvga_kb          |
// | Rev 1.0                                                             |
// +---------------------------------------------------------------------+
interface crvga_kb_if;

   logic        iCrvgaR;
   logic        iCrvgaG;
   logic        iCrvgaB;
   logic        oCrvgaR;
   logic        oCrvgaG;
   logic        oCrvgaB;
   logic        hoz_sync;
   logic        ver_sync;
   logic [31:0] oCurrentCol;
   logic [31:0] oCurrentRow;
   logic        clk_kb;
   logic        data_kb;
   logic [7:0]  out_reg;

   modport master (
      output iCrvgaR, iCrvgaG, iCrvgaB, clk_kb, data_kb,
      input  oCrvgaR, oCrvgaG, oCrvgaB, hoz_sync, ver_sync,
             oCurrentCol, oCurrentRow, out_reg
   );

   modport slave (
      input  iCrvgaR, iCrvgaG, iCrvgaB, clk_kb, data_kb,
      output oCrvgaR, oCrvgaG, oCrvgaB, hoz_sync, ver_sync,
             oCurrentCol, oCurrentRow, out_reg
   );

endinterface
`default_nettype wire

// File: rtl/crvga_kb_ps2_rx.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | ps2_rx : PS/2 keyboard receiver with synchronisers and idle timeout |
// | Rev 1.0                                                             |
// +---------------------------------------------------------------------+
module ps2_rx
   import crvga_kb_pkg::*;
#(
   parameter int TIMEOUT = KB_TIMEOUT
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       clk_kb,
   input  logic       data_kb,
   output logic [7:0] out_reg
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int BW = $clog2(PS2_FRAME_BITS);

   logic [1:0]    clk_sync;
   logic [1:0]    data_sync;
   logic          clk_prev;
   logic [BW-1:0] bit_cnt;
   ps2_frame_t    shift;
   logic [TW-1:0] idle_cnt;
   logic          frame_done;
   logic          fall;

   assign fall = clk_prev & ~clk_sync[1];

   always_ff @(posedge clock) begin
      if (reset) begin
         clk_sync   <= 2'b11;
         data_sync  <= 2'b11;
         clk_prev   <= 1'b1;
         bit_cnt    <= '0;
         shift      <= '0;
         idle_cnt   <= '0;
         frame_done <= 1'b0;
         out_reg    <= '0;
      end else begin
         clk_sync   <= {clk_sync[0], clk_kb};
         data_sync  <= {data_sync[0], data_kb};
         clk_prev   <= clk_sync[1];
         frame_done <= 1'b0;

         // Bits shift in from the top so the start bit lands in bit 0 after the 11th edge.
         if (fall) begin
            shift    <= {data_sync[1], shift[PS2_FRAME_BITS-1:1]};
            idle_cnt <= '0;
            if (bit_cnt == BW'(PS2_FRAME_BITS - 1)) begin
               bit_cnt    <= '0;
               frame_done <= 1'b1;
            end else begin
               bit_cnt <= bit_cnt + 1'b1;
            end
         end else if (bit_cnt != '0) begin
            if (idle_cnt == TW'(TIMEOUT - 1)) begin
               bit_cnt  <= '0;
               idle_cnt <= '0;
            end else begin
               idle_cnt <= idle_cnt + 1'b1;
            end
         end

         if (frame_done && ps2_frame_ok(shift)) begin
            out_reg <= shift[8:1];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/crvga_kb.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | crvga_kb : 640x480 VGA timing/colour gating plus PS/2 scan capture  |
// | Rev 1.0                                                             |
// +---------------------------------------------------------------------+
module crvga_kb
   import crvga_kb_pkg::*;
#(
   parameter int H_VISIBLE     = H_VIS,
   parameter int H_FRONT       = H_FP,
   parameter int H_PULSE       = H_SYNC,
   parameter int H_BACK        = H_BP,
   parameter int V_VISIBLE     = V_VIS,
   parameter int V_FRONT       = V_FP,
   parameter int V_PULSE       = V_SYNC,
   parameter int V_BACK        = V_BP,
   parameter int KB_IDLE_LIMIT = KB_TIMEOUT
) (
   input  logic       clock,
   input  logic       reset,
   crvga_kb_if.slave  bus
);

   localparam int H_TOT = H_VISIBLE + H_FRONT + H_PULSE + H_BACK;
   localparam int V_TOT = V_VISIBLE + V_FRONT + V_PULSE + V_BACK;

   logic        pix_en;
   logic [31:0] col;
   logic [31:0] row;
   logic        visible;
   rgb_t        pix_in;
   rgb_t        pix_out;
   logic [7:0]  kb_code;

   // Pixel clock is half the system clock; counters move on the cycles pix_en is high.
   always_ff @(posedge clock) begin
      if (reset) begin
         pix_en <= 1'b0;
         col    <= '0;
         row    <= '0;
      end else begin
         pix_en <= ~pix_en;
         if (pix_en) begin
            if (col == 32'(H_TOT - 1)) begin
               col <= '0;
               row <= (row == 32'(V_TOT - 1)) ? '0 : row + 32'd1;
            end else begin
               col <= col + 32'd1;
            end
         end
      end
   end

   always_comb begin
      pix_in  = {bus.iCrvgaR, bus.iCrvgaG, bus.iCrvgaB};
      visible = (col < 32'(H_VISIBLE)) && (row < 32'(V_VISIBLE));
      pix_out = visible ? pix_in : '0;
   end

   assign bus.oCrvgaR     = pix_out.r;
   assign bus.oCrvgaG     = pix_out.g;
   assign bus.oCrvgaB     = pix_out.b;
   assign bus.hoz_sync    = ~((col >= 32'(H_VISIBLE + H_FRONT)) &&
                              (col <  32'(H_VISIBLE + H_FRONT + H_PULSE)));
   assign bus.ver_sync    = ~((row >= 32'(V_VISIBLE + V_FRONT)) &&
                              (row <  32'(V_VISIBLE + V_FRONT + V_PULSE)));
   assign bus.oCurrentCol = col;
   assign bus.oCurrentRow = row;
   assign bus.out_reg     = kb_code;

   ps2_rx #(
      .TIMEOUT (KB_IDLE_LIMIT)
   ) u_ps2_rx (
      .clock   (clock),
      .reset   (reset),
      .clk_kb  (bus.clk_kb),
      .data_kb (bus.data_kb),
      .out_reg (kb_code)
   );

endmodule
`default_nettype wire

// File: tb/tb_crvga_kb.sv
`timescale 1ns/1ps
`default_nettype none
// +---------------------------------------------------------------------+
// | tb_crvga_kb : randomized self-checking bench for crvga_kb           |
// | Rev 1.0                                                             |
// +---------------------------------------------------------------------+
module tb_crvga_kb;

   // Short vertical frame and idle limit keep a whole frame and a timeout within the run.
   localparam int VV       = 6;
   localparam int VF       = 2;
   localparam int VS       = 2;
   localparam int VB       = 3;
   localparam int VT       = VV + VF + VS + VB;
   localparam int HT       = 800;
   localparam int TMO      = 300;
   localparam int PS2_HALF = 20;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   errors = 0;
   int   checks = 0;
   longint cyc;
   logic [7:0] kb_exp;

   crvga_kb_if bus();

   crvga_kb #(
      .V_VISIBLE     (VV),
      .V_FRONT       (VF),
      .V_PULSE       (VS),
      .V_BACK        (VB),
      .KB_IDLE_LIMIT (TMO)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #10 clock = ~clock;

   always @(posedge clock) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   wire [2:0] dut_rgb = {bus.oCrvgaR, bus.oCrvgaG, bus.oCrvgaB};

   // Reference: one pixel per two clocks since reset release, raster of HT x VT pixels.
   function automatic int m_col(input longint c);
      return int'((c / 2) % HT);
   endfunction
   function automatic int m_row(input longint c);
      return int'((c / (2 * HT)) % VT);
   endfunction
   function automatic logic m_hs(input int c);
      return !(c >= 656 && c < 752);
   endfunction
   function automatic logic m_vs(input int r);
      return !(r >= VV + VF && r < VV + VF + VS);
   endfunction
   function automatic logic [2:0] m_rgb(input int c, input int r, input logic [2:0] in);
      return (c < 640 && r < VV) ? in : 3'b000;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick(3);
      reset = 1'b0;
      kb_exp = 8'h00;
   endtask

   task automatic set_rgb(input logic [2:0] v);
      {bus.iCrvgaR, bus.iCrvgaG, bus.iCrvgaB} = v;
   endtask

   task automatic ps2_send(input logic [7:0] b, input logic bad_par, input logic stop,
                           input int nbits);
      logic [10:0] f;
      f = {stop, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         bus.data_kb = f[i];
         tick(PS2_HALF);
         bus.clk_kb = 1'b0;
         tick(PS2_HALF);
         bus.clk_kb = 1'b1;
      end
      bus.data_kb = 1'b1;
      tick(PS2_HALF);
      if (nbits == 11 && !bad_par && stop) kb_exp = b;
   endtask

   task automatic test_reset();
      logic [2:0] in;
      in = 3'($urandom_range(1, 7));
      set_rgb(in);
      reset = 1'b1;
      tick(4);
      checks++;
      if (bus.oCurrentCol !== 32'd0 || bus.oCurrentRow !== 32'd0) begin
         errors++;
         $display("FAIL reset_counters: col=%0d row=%0d want 0 0", bus.oCurrentCol, bus.oCurrentRow);
      end
      checks++;
      if (bus.hoz_sync !== 1'b1 || bus.ver_sync !== 1'b1) begin
         errors++;
         $display("FAIL reset_sync: hs=%b vs=%b want 1 1", bus.hoz_sync, bus.ver_sync);
      end
      checks++;
      if (dut_rgb !== in) begin
         errors++;
         $display("FAIL reset_rgb: got %b want %b", dut_rgb, in);
      end
      checks++;
      if (bus.out_reg !== 8'h00) begin
         errors++;
         $display("FAIL reset_out_reg: got %h want 00", bus.out_reg);
      end
      reset = 1'b0;
      kb_exp = 8'h00;
      tick(1);
      checks++;
      if (bus.oCurrentCol !== 32'd0 || bus.hoz_sync !== 1'b1 || dut_rgb !== in) begin
         errors++;
         $display("FAIL after_reset: col=%0d hs=%b rgb=%b want 0 1 %b",
                  bus.oCurrentCol, bus.hoz_sync, dut_rgb, in);
      end
   endtask

   task automatic test_timing_random();
      logic [2:0] in;
      int c, r;
      do_reset();
      for (int k = 0; k < 40; k++) begin
         tick($urandom_range(1, 900));
         in = 3'($urandom);
         set_rgb(in);
         #1;
         c = m_col(cyc);
         r = m_row(cyc);
         checks++;
         if (bus.oCurrentCol !== 32'(c) || bus.oCurrentRow !== 32'(r) ||
             bus.hoz_sync !== m_hs(c) || bus.ver_sync !== m_vs(r) ||
             dut_rgb !== m_rgb(c, r, in)) begin
            errors++;
            $display("FAIL timing_rand: col=%0d row=%0d hs=%b vs=%b rgb=%b want %0d %0d %b %b %b",
                     bus.oCurrentCol, bus.oCurrentRow, bus.hoz_sync, bus.ver_sync, dut_rgb,
                     c, r, m_hs(c), m_vs(r), m_rgb(c, r, in));
         end
      end
   endtask

   task automatic test_line_wrap();
      int wraps;
      logic [31:0] prev;
      do_reset();
      wraps = 0;
      prev  = bus.oCurrentCol;
      for (int i = 0; i < 1600; i++) begin
         tick(1);
         if (prev == 32'd799 && bus.oCurrentCol == 32'd0) wraps++;
         prev = bus.oCurrentCol;
      end
      checks++;
      if (wraps !== 1) begin
         errors++;
         $display("FAIL line_wraps: got %0d want 1", wraps);
      end
      checks++;
      if (bus.oCurrentRow !== 32'd1 || bus.oCurrentCol !== 32'd0) begin
         errors++;
         $display("FAIL line_end_pos: row=%0d col=%0d want 1 0", bus.oCurrentRow, bus.oCurrentCol);
      end
   endtask

   task automatic test_hsync_width();
      int low, first;
      do_reset();
      low   = 0;
      first = -1;
      for (int i = 0; i < 1600; i++) begin
         tick(1);
         if (bus.hoz_sync == 1'b0) begin
            low++;
            if (first < 0) first = int'(bus.oCurrentCol);
         end
      end
      checks++;
      if (low !== 192) begin
         errors++;
         $display("FAIL hsync_clocks: got %0d want 192", low);
      end
      checks++;
      if (first !== 656) begin
         errors++;
         $display("FAIL hsync_start_col: got %0d want 656", first);
      end
   endtask

   task automatic test_vsync_frame();
      int vlow, rmin, rmax, wrap_at;
      logic [31:0] prev;
      do_reset();
      vlow = 0; rmin = 9999; rmax = -1; wrap_at = -1;
      prev = bus.oCurrentRow;
      for (int i = 1; i <= VT * 2 * HT; i++) begin
         tick(1);
         if (bus.ver_sync == 1'b0) begin
            vlow++;
            if (int'(bus.oCurrentRow) < rmin) rmin = int'(bus.oCurrentRow);
            if (int'(bus.oCurrentRow) > rmax) rmax = int'(bus.oCurrentRow);
         end
         if (prev == 32'(VT - 1) && bus.oCurrentRow == 32'd0 && wrap_at < 0) wrap_at = i;
         prev = bus.oCurrentRow;
      end
      checks++;
      if (vlow !== VS * 2 * HT) begin
         errors++;
         $display("FAIL vsync_clocks: got %0d want %0d", vlow, VS * 2 * HT);
      end
      checks++;
      if (rmin !== VV + VF || rmax !== VV + VF + VS - 1) begin
         errors++;
         $display("FAIL vsync_rows: got %0d..%0d want %0d..%0d", rmin, rmax, VV + VF, VV + VF + VS - 1);
      end
      checks++;
      if (wrap_at !== VT * 2 * HT) begin
         errors++;
         $display("FAIL row_wrap_clock: got %0d want %0d", wrap_at, VT * 2 * HT);
      end
   endtask

   task automatic test_colour_boundary();
      int n;
      set_rgb(3'b111);
      do_reset();
      n = 0;
      while (bus.oCurrentCol != 32'd639 && n < 2000) begin tick(1); n++; end
      checks++;
      if (n >= 2000) begin
         errors++;
         $display("FAIL col639_wait: timed out after %0d clocks", n);
      end else if (dut_rgb !== 3'b111 || bus.oCurrentRow !== 32'd0) begin
         errors++;
         $display("FAIL rgb_col639: got %b row %0d want 111 row 0", dut_rgb, bus.oCurrentRow);
      end
      n = 0;
      while (bus.oCurrentCol != 32'd640 && n < 10) begin tick(1); n++; end
      checks++;
      if (n >= 10) begin
         errors++;
         $display("FAIL col640_wait: timed out after %0d clocks", n);
      end else if (dut_rgb !== 3'b000) begin
         errors++;
         $display("FAIL rgb_col640: got %b want 000", dut_rgb);
      end
      n = 0;
      while (!(bus.oCurrentRow == 32'(VV) && bus.oCurrentCol == 32'd0) && n < VT * 2 * HT) begin
         tick(1);
         n++;
      end
      checks++;
      if (n >= VT * 2 * HT) begin
         errors++;
         $display("FAIL row_vis_end_wait: timed out after %0d clocks", n);
      end else if (dut_rgb !== 3'b000) begin
         errors++;
         $display("FAIL rgb_row_end: got %b want 000", dut_rgb);
      end
   endtask

   task automatic test_ps2_basic();
      logic [7:0] codes [3];
      codes[0] = 8'h23; codes[1] = 8'hF0; codes[2] = 8'hE0;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         ps2_send(codes[i], 1'b0, 1'b1, 11);
         checks++;
         if (bus.out_reg !== codes[i]) begin
            errors++;
            $display("FAIL ps2_code_%0d: got %h want %h", i, bus.out_reg, codes[i]);
         end
      end
   endtask

   task automatic test_ps2_errors();
      ps2_send(8'h23, 1'b0, 1'b1, 11);
      ps2_send(8'h1C, 1'b1, 1'b1, 11);
      checks++;
      if (bus.out_reg !== 8'h23) begin
         errors++;
         $display("FAIL ps2_bad_parity: got %h want 23", bus.out_reg);
      end
      ps2_send(8'h1C, 1'b0, 1'b0, 11);
      checks++;
      if (bus.out_reg !== 8'h23) begin
         errors++;
         $display("FAIL ps2_bad_stop: got %h want 23", bus.out_reg);
      end
      ps2_send(8'h1C, 1'b0, 1'b1, 6);
      tick(TMO + 50);
      checks++;
      if (bus.out_reg !== 8'h23) begin
         errors++;
         $display("FAIL ps2_partial: got %h want 23", bus.out_reg);
      end
      ps2_send(8'h1C, 1'b0, 1'b1, 11);
      checks++;
      if (bus.out_reg !== 8'h1C) begin
         errors++;
         $display("FAIL ps2_after_timeout: got %h want 1c", bus.out_reg);
      end
   endtask

   task automatic test_ps2_random();
      logic [7:0] b;
      logic bad_par, stop;
      for (int i = 0; i < 8; i++) begin
         b       = 8'($urandom);
         bad_par = ($urandom_range(0, 3) == 0);
         stop    = ($urandom_range(0, 3) != 0);
         ps2_send(b, bad_par, stop, 11);
         checks++;
         if (bus.out_reg !== kb_exp) begin
            errors++;
            $display("FAIL ps2_rand_%0d: got %h want %h (byte %h par_err %b stop %b)",
                     i, bus.out_reg, kb_exp, b, bad_par, stop);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      ps2_send(8'h5A, 1'b0, 1'b1, 5);
      reset = 1'b1;
      tick(3);
      checks++;
      if (bus.out_reg !== 8'h00) begin
         errors++;
         $display("FAIL ps2_mid_reset: got %h want 00", bus.out_reg);
      end
      reset = 1'b0;
      kb_exp = 8'h00;
      tick(2);
      ps2_send(8'h3B, 1'b0, 1'b1, 11);
      checks++;
      if (bus.out_reg !== 8'h3B) begin
         errors++;
         $display("FAIL ps2_after_reset: got %h want 3b", bus.out_reg);
      end
   endtask

   initial begin
      set_rgb(3'b000);
      bus.clk_kb  = 1'b1;
      bus.data_kb = 1'b1;
      kb_exp      = 8'h00;
      tick(2);
      test_reset();
      test_timing_random();
      test_line_wrap();
      test_hsync_width();
      test_vsync_frame();
      test_colour_boundary();
      test_ps2_basic();
      test_ps2_errors();
      test_ps2_random();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_900_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
